// File: rtl/video_ddr_pkg.sv
// Shared definitions for the video DDR write path: FSM encoding, beat geometry
// and the beat-pointer to DDR-address conversion.
package video_ddr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AW   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int BEAT_BYTES = 32;
  localparam logic [BEAT_BYTES-1:0] WSTRB_ALL = '1;
  localparam int DDR_UNITS_PER_BEAT = 8;

  // A beat pointer counts 256-bit words; DDR addresses count DQ-wide units.
  function automatic logic [31:0] beat_to_units(input logic [15:0] ptr);
    return 32'(ptr) * 32'(DDR_UNITS_PER_BEAT);
  endfunction

endpackage

// File: rtl/wr_beat_skid.sv
// One-entry valid/ready skid register with bypass: an arriving beat goes
// straight out when the register is empty, and is parked when the sink stalls.
module wr_beat_skid
  import video_ddr_pkg::*;
#(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  assign in_ready  = !full_reg || out_ready;
  assign out_valid = full_reg || in_valid;
  assign out_data  = full_reg ? data_reg : (in_valid ? in_data : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (full_reg) begin
      if (out_ready) begin
        full_reg <= in_valid;
        if (in_valid) data_reg <= in_data;
      end
    end else if (in_valid && !out_ready) begin
      full_reg <= 1'b1;
      data_reg <= in_data;
    end
  end

endmodule

// File: rtl/ddr_burst_writer.sv
// Drains one half of a sampling line buffer as an AXI-style write burst to DDR.
// Define FRAME_PINGPONG_EN to alternate between two frame buffers in DDR.
module ddr_burst_writer
  import video_ddr_pkg::*;
#(
  parameter int                    DQ_WIDTH    = 32,
  parameter int                    RD_ADDR_LEN = 5,
  parameter int                    BURST_LEN   = 16,
  parameter int                    ADDR_WIDTH  = 28,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = '0,
  parameter int                    FRAME_WORDS = 3600
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   src_ready,
  input  logic [3:0]             src_trans_id,
  input  logic                   src_frame_end,
  output logic                   src_rd_valid,
  output logic [RD_ADDR_LEN-1:0] src_rd_addr,
  input  logic [DQ_WIDTH*8-1:0]  src_rd_data,
  output logic [ADDR_WIDTH-1:0]  axi_awaddr,
  output logic [7:0]             axi_awlen,
  output logic [3:0]             axi_awid,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [DQ_WIDTH*8-1:0]  axi_wdata,
  output logic [DQ_WIDTH-1:0]    axi_wstrb,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  output logic                   axi_wlast,
  output logic                   frame_sel,
  output logic                   busy
);

  localparam int BEAT_W = RD_ADDR_LEN - 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]            state_reg, state_next;
  logic [15:0]           wr_ptr_reg;
  logic                  half_sel_reg;
  logic                  frame_pend_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [3:0]            awid_reg;
  logic [BEAT_W-1:0]     beat_idx_reg;
  logic                  rd_pend_reg;
  logic [BEAT_W-1:0]     out_idx_reg;

  logic                  aw_hs, w_hs, rd_adv, skid_in_ready;
  logic                  frame_hit, frame_apply, ptr_wrap;
  logic [16:0]           ptr_step;
  logic [ADDR_WIDTH-1:0] fbase, aw_addr_calc;
  logic [BEAT_W-1:0]     beat_idx_inc;

  assign aw_hs        = axi_awvalid && axi_awready;
  assign w_hs         = axi_wvalid && axi_wready;
  // beat_idx_reg is the beat currently on src_rd_data; it moves on only once
  // that beat has a place to go, otherwise its address is re-presented.
  assign rd_adv       = (state_reg == ST_WR) && rd_pend_reg && skid_in_ready;
  assign beat_idx_inc = beat_idx_reg + BEAT_W'(1);
  assign frame_hit    = frame_pend_reg || src_frame_end;
  assign frame_apply  = (state_reg == ST_DONE) && frame_hit;
  assign ptr_step     = {1'b0, wr_ptr_reg} + 17'(BURST_LEN);
  assign ptr_wrap     = ptr_step >= 17'(FRAME_WORDS);
  assign aw_addr_calc = fbase + ADDR_WIDTH'(beat_to_units(wr_ptr_reg));

`ifdef FRAME_PINGPONG_EN
  localparam logic [ADDR_WIDTH-1:0] FB1_OFS = ADDR_WIDTH'(FRAME_WORDS * DDR_UNITS_PER_BEAT);
  logic fb_idx_reg, frame_sel_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_idx_reg    <= 1'b0;
      frame_sel_reg <= 1'b0;
    end else if (frame_apply) begin
      frame_sel_reg <= fb_idx_reg;
      fb_idx_reg    <= ~fb_idx_reg;
    end
  end

  assign fbase     = fb_idx_reg ? FRAME_BASE + FB1_OFS : FRAME_BASE;
  assign frame_sel = frame_sel_reg;
`else
  assign fbase     = FRAME_BASE;
  assign frame_sel = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (src_ready) state_next = ST_AW;
      ST_AW:   if (aw_hs) state_next = ST_WR;
      ST_WR:   if (w_hs && axi_wlast) state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      wr_ptr_reg     <= '0;
      half_sel_reg   <= 1'b0;
      frame_pend_reg <= 1'b0;
      awaddr_reg     <= '0;
      awid_reg       <= '0;
      beat_idx_reg   <= '0;
      rd_pend_reg    <= 1'b0;
      out_idx_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && src_ready) begin
        awaddr_reg <= aw_addr_calc;
        awid_reg   <= src_trans_id;
      end
      if (aw_hs) begin
        beat_idx_reg <= '0;
        rd_pend_reg  <= 1'b1;
        out_idx_reg  <= '0;
      end else begin
        if (rd_adv) begin
          beat_idx_reg <= beat_idx_inc;
          if (beat_idx_reg == LAST_BEAT) rd_pend_reg <= 1'b0;
        end
        if (w_hs) out_idx_reg <= out_idx_reg + BEAT_W'(1);
      end
      if (frame_apply) begin
        wr_ptr_reg     <= '0;
        half_sel_reg   <= 1'b0;
        frame_pend_reg <= 1'b0;
      end else if (state_reg == ST_DONE) begin
        half_sel_reg <= ~half_sel_reg;
        wr_ptr_reg   <= ptr_wrap ? 16'd0 : ptr_step[15:0];
      end else if (src_frame_end) begin
        frame_pend_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    src_rd_addr = '0;
    case (state_reg)
      ST_AW:   src_rd_addr = {half_sel_reg, {BEAT_W{1'b0}}};
      ST_WR:   src_rd_addr = {half_sel_reg, rd_adv ? beat_idx_inc : beat_idx_reg};
      default: src_rd_addr = '0;
    endcase
  end

  wr_beat_skid #(.W(DQ_WIDTH * 8)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_pend_reg),
    .in_data   (src_rd_data),
    .in_ready  (skid_in_ready),
    .out_valid (axi_wvalid),
    .out_data  (axi_wdata),
    .out_ready (axi_wready)
  );

  generate
    if (DQ_WIDTH == BEAT_BYTES) begin : g_wstrb_pkg
      assign axi_wstrb = WSTRB_ALL;
    end else begin : g_wstrb_param
      assign axi_wstrb = '1;
    end
  endgenerate

  assign axi_wlast    = axi_wvalid && (out_idx_reg == LAST_BEAT);
  assign axi_awvalid  = (state_reg == ST_AW);
  assign axi_awaddr   = awaddr_reg;
  assign axi_awid     = awid_reg;
  assign axi_awlen    = axi_awvalid ? 8'(BURST_LEN - 1) : 8'd0;
  assign src_rd_valid = (state_reg == ST_AW) || (state_reg == ST_WR);
  assign busy         = (state_reg != ST_IDLE);

endmodule
